// File: rtl/dispatch_wide.sv
// ---------------------------------------------------------------------------
// dispatch_wide
//   N-lane in-order dispatch stage. Decoded instructions are buffered in a
//   small circular queue. Each cycle an in-order prefix of up to WIDTH queue
//   entries is renamed through the RAT and free list, given ROB indices and
//   handed to the reservation stations. Source operands that depend on an
//   older instruction in the same dispatch group are bypassed from that
//   lane's newly allocated physical register.
//
// Optional feature macro: DISPATCH_PERF_EN
//   When defined, adds saturating 32-bit counters perf_dispatched (number of
//   instructions dispatched) and perf_stall (cycles with stall_dispatch=1).
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   flush               branch-recovery flush, empties the queue
//   in_valid/in_inst    decode lanes (contiguous from lane 0) / in_ready
//   rs1/rs2_archreg     RAT read addresses, rs1/rs2_mapping RAT read data
//   rename_en, rat_arch_dst, rat_phys_dst   RAT write port per lane
//   fl_count, preg_addr, preg_request       free-list interface
//   rob_free, rob_idx, rob_pkt              ROB interface
//   res_full, res_entry_out                 reservation-station interface
//   stall_dispatch      queue non-empty but nothing dispatched
// ---------------------------------------------------------------------------
package dispatch_wide_pkg;
    localparam int ARCH_WIDTH       = 5;
    localparam int PHYS_WIDTH       = 6;
    localparam int ROB_ADDR_WIDTH   = 4;
    localparam int NUM_RES_STATIONS = 4;
    localparam int RES_ID_WIDTH     = 2;

    typedef struct packed {
        logic                      i_valid;
        logic [7:0]                opcode;
        logic                      i_uses_rd;
        logic [ARCH_WIDTH-1:0]     rd_addr;
        logic [ARCH_WIDTH-1:0]     rs1_addr;
        logic [ARCH_WIDTH-1:0]     rs2_addr;
        logic [PHYS_WIDTH-1:0]     rd_paddr;
        logic [PHYS_WIDTH-1:0]     rs1_paddr;
        logic [PHYS_WIDTH-1:0]     rs2_paddr;
        logic [RES_ID_WIDTH-1:0]   res_id;
        logic [ROB_ADDR_WIDTH-1:0] i_rob_idx;
    } instr_pkt;

    typedef struct packed {
        instr_pkt inst;
        logic     valid;
        logic     stall;
    } res_entry;
endpackage

module dispatch_wide
    import dispatch_wide_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int QDEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [WIDTH-1:0]                       in_valid,
    input  instr_pkt [WIDTH-1:0]                   in_inst,
    output logic                                   in_ready,
    output logic [WIDTH-1:0][ARCH_WIDTH-1:0]       rs1_archreg,
    output logic [WIDTH-1:0][ARCH_WIDTH-1:0]       rs2_archreg,
    input  logic [WIDTH-1:0][PHYS_WIDTH-1:0]       rs1_mapping,
    input  logic [WIDTH-1:0][PHYS_WIDTH-1:0]       rs2_mapping,
    output logic [WIDTH-1:0]                       rename_en,
    output logic [WIDTH-1:0][ARCH_WIDTH-1:0]       rat_arch_dst,
    output logic [WIDTH-1:0][PHYS_WIDTH-1:0]       rat_phys_dst,
    input  logic [PHYS_WIDTH:0]                    fl_count,
    input  logic [WIDTH-1:0][PHYS_WIDTH-1:0]       preg_addr,
    output logic [WIDTH-1:0]                       preg_request,
    input  logic [ROB_ADDR_WIDTH:0]                rob_free,
    input  logic [ROB_ADDR_WIDTH-1:0]              rob_idx,
    output instr_pkt [WIDTH-1:0]                   rob_pkt,
    input  logic [NUM_RES_STATIONS-1:0]            res_full,
    output res_entry [WIDTH-1:0]                   res_entry_out,
`ifdef DISPATCH_PERF_EN
    output logic [31:0]                            perf_dispatched,
    output logic [31:0]                            perf_stall,
`endif
    output logic                                   stall_dispatch
);

    localparam int PW  = $clog2(QDEPTH);
    localparam int CW  = PW + 1;
    localparam int RW  = ROB_ADDR_WIDTH + 1;
    localparam int FLW = PHYS_WIDTH + 1;

    instr_pkt                         queueMem [QDEPTH];
    logic [PW-1:0]                    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [CW-1:0]                    enqCnt, enqAccepted, deqCnt;
    logic                             doEnq;

    instr_pkt [WIDTH-1:0]             cand;
    logic [WIDTH-1:0]                 needsRd, dispLane, dstUsed;
    logic [WIDTH-1:0][PHYS_WIDTH-1:0] physDst, rs1Phys, rs2Phys;
    logic [NUM_RES_STATIONS-1:0]      stationUsed;
    logic                             dispOk;
    int                               rdNum;

    // Space check uses the registered count only, so a full queue never
    // depends combinationally on this cycle's dispatch decision.
    assign in_ready = (CW'(QDEPTH) - count_q) >= CW'(WIDTH);
    assign doEnq    = in_ready && !flush;

    // Decode lanes are contiguous from lane 0, so the popcount of in_valid
    // is also the index bound of the lanes to write.
    always_comb begin
        enqCnt = '0;
        for (int k = 0; k < WIDTH; k++) begin
            enqCnt = enqCnt + CW'(in_valid[k]);
        end
        enqAccepted = doEnq ? enqCnt : '0;
    end

    // Queue storage; contents need no reset because count_q qualifies them.
    always_ff @(posedge clk) begin
        if (doEnq) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (CW'(k) < enqCnt) begin
                    queueMem[tail_q + PW'(k)] <= in_inst[k];
                end
            end
        end
    end

    // Dispatch selection, renaming and intra-group bypass. The lane chain
    // stops at the first lane that cannot go, keeping dispatch in order.
    always_comb begin
        dispOk        = 1'b1;
        rdNum         = 0;
        stationUsed   = '0;
        deqCnt        = '0;
        cand          = '0;
        needsRd       = '0;
        dispLane      = '0;
        dstUsed       = '0;
        physDst       = '0;
        rs1Phys       = '0;
        rs2Phys       = '0;
        rename_en     = '0;
        preg_request  = '0;
        rs1_archreg   = '0;
        rs2_archreg   = '0;
        rat_arch_dst  = '0;
        rat_phys_dst  = '0;
        rob_pkt       = '0;
        res_entry_out = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cand[k]        = queueMem[head_q + PW'(k)];
            needsRd[k]     = cand[k].i_uses_rd && (cand[k].rd_addr != '0);
            rs1_archreg[k] = cand[k].rs1_addr;
            rs2_archreg[k] = cand[k].rs2_addr;

            // Free-list slot j goes to the j-th renaming lane of this group.
            for (int j = 0; j < WIDTH; j++) begin
                if (j == rdNum) physDst[k] = preg_addr[j];
            end

            dispOk = dispOk && !flush
                   && (CW'(k) < count_q)
                   && (rob_free > RW'(k))
                   && (FLW'(rdNum + (needsRd[k] ? 1 : 0)) <= fl_count)
                   && !res_full[cand[k].res_id]
                   && !stationUsed[cand[k].res_id];
            dispLane[k] = dispOk;

            if (dispOk) begin
                deqCnt                      = deqCnt + CW'(1);
                stationUsed[cand[k].res_id] = 1'b1;
                if (needsRd[k]) begin
                    rename_en[k] = 1'b1;
                    dstUsed[k]   = 1'b1;
                    for (int j = 0; j < WIDTH; j++) begin
                        if (j == rdNum) preg_request[j] = 1'b1;
                    end
                    rdNum = rdNum + 1;
                end
            end

            // Ascending scan so the youngest older producer overrides.
            rs1Phys[k] = rs1_mapping[k];
            rs2Phys[k] = rs2_mapping[k];
            for (int j = 0; j < k; j++) begin
                if (dstUsed[j] && (cand[j].rd_addr == cand[k].rs1_addr)) rs1Phys[k] = physDst[j];
                if (dstUsed[j] && (cand[j].rd_addr == cand[k].rs2_addr)) rs2Phys[k] = physDst[j];
            end

            rat_arch_dst[k]       = cand[k].rd_addr;
            rat_phys_dst[k]       = physDst[k];
            rob_pkt[k]            = cand[k];
            rob_pkt[k].i_valid    = dispLane[k];
            rob_pkt[k].rd_paddr   = dstUsed[k] ? physDst[k] : '0;
            rob_pkt[k].rs1_paddr  = rs1Phys[k];
            rob_pkt[k].rs2_paddr  = rs2Phys[k];
            rob_pkt[k].i_rob_idx  = rob_idx + ROB_ADDR_WIDTH'(k);
            res_entry_out[k].inst  = rob_pkt[k];
            res_entry_out[k].valid = 1'b0;
            res_entry_out[k].stall = 1'b0;
        end
    end

    assign stall_dispatch = (count_q != '0) && (deqCnt == '0);

    // Pointer and occupancy next-state; flush discards everything.
    always_comb begin
        head_d  = head_q + PW'(deqCnt);
        tail_d  = tail_q + PW'(enqAccepted);
        count_d = count_q + enqAccepted - deqCnt;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0] perfDisp_q, perfStall_q;

    // Saturating event counters; flush deliberately does not clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perfDisp_q  <= '0;
            perfStall_q <= '0;
        end else begin
            if (perfDisp_q > (32'hFFFF_FFFF - 32'(deqCnt))) begin
                perfDisp_q <= '1;
            end else begin
                perfDisp_q <= perfDisp_q + 32'(deqCnt);
            end
            if (stall_dispatch && (perfStall_q != '1)) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_dispatched = perfDisp_q;
    assign perf_stall      = perfStall_q;
`endif

endmodule

// File: tb/tb_dispatch_wide.sv
// ---------------------------------------------------------------------------
// tb_dispatch_wide
//   Directed testbench for dispatch_wide (WIDTH=2, QDEPTH=8). The RAT is
//   stubbed so that arch reg xN maps to physical reg 32+N; free-list slots
//   present physical regs 17 and 18.
// ---------------------------------------------------------------------------
module tb_dispatch_wide;
    import dispatch_wide_pkg::*;

    localparam int WIDTH  = 2;
    localparam int QDEPTH = 8;

    logic                                   clk;
    logic                                   rst;
    logic                                   flush;
    logic [WIDTH-1:0]                       in_valid;
    instr_pkt [WIDTH-1:0]                   in_inst;
    logic                                   in_ready;
    logic [WIDTH-1:0][ARCH_WIDTH-1:0]       rs1_archreg, rs2_archreg;
    logic [WIDTH-1:0][PHYS_WIDTH-1:0]       rs1_mapping, rs2_mapping;
    logic [WIDTH-1:0]                       rename_en;
    logic [WIDTH-1:0][ARCH_WIDTH-1:0]       rat_arch_dst;
    logic [WIDTH-1:0][PHYS_WIDTH-1:0]       rat_phys_dst;
    logic [PHYS_WIDTH:0]                    fl_count;
    logic [WIDTH-1:0][PHYS_WIDTH-1:0]       preg_addr;
    logic [WIDTH-1:0]                       preg_request;
    logic [ROB_ADDR_WIDTH:0]                rob_free;
    logic [ROB_ADDR_WIDTH-1:0]              rob_idx;
    instr_pkt [WIDTH-1:0]                   rob_pkt;
    logic [NUM_RES_STATIONS-1:0]            res_full;
    res_entry [WIDTH-1:0]                   res_entry_out;
    logic                                   stall_dispatch;
`ifdef DISPATCH_PERF_EN
    logic [31:0]                            perf_dispatched, perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    dispatch_wide #(.WIDTH(WIDTH), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_inst        (in_inst),
        .in_ready       (in_ready),
        .rs1_archreg    (rs1_archreg),
        .rs2_archreg    (rs2_archreg),
        .rs1_mapping    (rs1_mapping),
        .rs2_mapping    (rs2_mapping),
        .rename_en      (rename_en),
        .rat_arch_dst   (rat_arch_dst),
        .rat_phys_dst   (rat_phys_dst),
        .fl_count       (fl_count),
        .preg_addr      (preg_addr),
        .preg_request   (preg_request),
        .rob_free       (rob_free),
        .rob_idx        (rob_idx),
        .rob_pkt        (rob_pkt),
        .res_full       (res_full),
        .res_entry_out  (res_entry_out),
`ifdef DISPATCH_PERF_EN
        .perf_dispatched(perf_dispatched),
        .perf_stall     (perf_stall),
`endif
        .stall_dispatch (stall_dispatch)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAT stub: xN -> p(32+N).
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            rs1_mapping[k] = {1'b1, rs1_archreg[k]};
            rs2_mapping[k] = {1'b1, rs2_archreg[k]};
        end
    end

    function automatic instr_pkt mkInst(input logic usesRd, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [1:0] resId);
        instr_pkt p;
        p           = '0;
        p.i_valid   = 1'b1;
        p.opcode    = 8'h33;
        p.i_uses_rd = usesRd;
        p.rd_addr   = rd;
        p.rs1_addr  = rs1;
        p.rs2_addr  = rs2;
        p.res_id    = resId;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one decode group for one clock edge, then withdraw it.
    task automatic applyStimulus(input logic [1:0] valid, input instr_pkt i0, input instr_pkt i1);
        in_valid   = valid;
        in_inst[0] = i0;
        in_inst[1] = i1;
        @(posedge clk);
        #1;
        in_valid = '0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = '0;
        in_inst   = '0;
        fl_count  = 7'd10;
        rob_free  = 5'd8;
        rob_idx   = 4'd5;
        res_full  = '0;
        preg_addr[0] = 6'd17;
        preg_addr[1] = 6'd18;
        #2;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_stall", 32'(stall_dispatch), 32'd0);
        checkOutput("reset_rob_valid", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'd0);
        checkOutput("reset_preg_req", 32'(preg_request), 32'd0);
        checkOutput("reset_rename_en", 32'(rename_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Two independent renames with an intra-group rs1 dependency.
        applyStimulus(2'b11, mkInst(1'b1, 5'd1, 5'd3, 5'd4, 2'd0), mkInst(1'b1, 5'd2, 5'd1, 5'd5, 2'd1));
        checkOutput("t1_valid", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b11);
        checkOutput("t1_rob_idx0", 32'(rob_pkt[0].i_rob_idx), 32'd5);
        checkOutput("t1_rob_idx1", 32'(rob_pkt[1].i_rob_idx), 32'd6);
        checkOutput("t1_preg_req", 32'(preg_request), 32'b11);
        checkOutput("t1_rename_en", 32'(rename_en), 32'b11);
        checkOutput("t1_phys0", 32'(rat_phys_dst[0]), 32'd17);
        checkOutput("t1_phys1", 32'(rat_phys_dst[1]), 32'd18);
        checkOutput("t1_lane0_rs1", 32'(rob_pkt[0].rs1_paddr), 32'd35);
        checkOutput("t1_bypass_rs1", 32'(rob_pkt[1].rs1_paddr), 32'd17);
        checkOutput("t1_lane1_rs2", 32'(rob_pkt[1].rs2_paddr), 32'd37);
        checkOutput("t1_rs_idx1", 32'(res_entry_out[1].inst.i_rob_idx), 32'd6);
        checkOutput("t1_stall", 32'(stall_dispatch), 32'd0);
        tick();
        checkOutput("t1_drained", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'd0);

        // Same reservation station: one per cycle.
        applyStimulus(2'b11, mkInst(1'b1, 5'd6, 5'd0, 5'd0, 2'd2), mkInst(1'b1, 5'd7, 5'd0, 5'd0, 2'd2));
        checkOutput("t3_valid_a", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b01);
        checkOutput("t3_preg_req_a", 32'(preg_request), 32'b01);
        tick();
        checkOutput("t3_valid_b", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b01);
        checkOutput("t3_arch_b", 32'(rat_arch_dst[0]), 32'd7);
        tick();
        checkOutput("t3_valid_c", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'd0);
        checkOutput("t3_stall_c", 32'(stall_dispatch), 32'd0);

        // Free-list limit.
        fl_count = 7'd1;
        applyStimulus(2'b11, mkInst(1'b1, 5'd8, 5'd0, 5'd0, 2'd0), mkInst(1'b1, 5'd9, 5'd0, 5'd0, 2'd1));
        checkOutput("t4_valid_a", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b01);
        checkOutput("t4_preg_req_a", 32'(preg_request), 32'b01);
        tick();
        checkOutput("t4_valid_b", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b01);
        checkOutput("t4_arch_b", 32'(rat_arch_dst[0]), 32'd9);
        tick();

        // rd=x0 needs no free register even with an empty free list.
        fl_count = 7'd0;
        applyStimulus(2'b11, mkInst(1'b1, 5'd0, 5'd0, 5'd0, 2'd0), mkInst(1'b1, 5'd10, 5'd0, 5'd0, 2'd1));
        checkOutput("t4_x0_valid", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b01);
        checkOutput("t4_x0_rename", 32'(rename_en), 32'd0);
        checkOutput("t4_x0_preg_req", 32'(preg_request), 32'd0);
        checkOutput("t4_x0_rd_paddr", 32'(rob_pkt[0].rd_paddr), 32'd0);
        tick();
        checkOutput("t4_blocked_valid", 32'(rob_pkt[0].i_valid), 32'd0);
        checkOutput("t4_blocked_stall", 32'(stall_dispatch), 32'd1);
        fl_count = 7'd10;
        #1;
        checkOutput("t4_release_valid", 32'(rob_pkt[0].i_valid), 32'd1);
        checkOutput("t4_release_stall", 32'(stall_dispatch), 32'd0);
        tick();

        // ROB space limit.
        rob_free = 5'd1;
        applyStimulus(2'b11, mkInst(1'b0, 5'd0, 5'd1, 5'd2, 2'd0), mkInst(1'b0, 5'd0, 5'd3, 5'd4, 2'd1));
        checkOutput("t_robfree_valid", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b01);
        tick();
        checkOutput("t_robfree_next", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b01);
        tick();
        rob_free = 5'd8;

        // ROB index wrap.
        rob_idx = 4'd15;
        applyStimulus(2'b11, mkInst(1'b0, 5'd0, 5'd1, 5'd2, 2'd0), mkInst(1'b0, 5'd0, 5'd3, 5'd4, 2'd1));
        checkOutput("t5_valid", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'b11);
        checkOutput("t5_idx0", 32'(rob_pkt[0].i_rob_idx), 32'd15);
        checkOutput("t5_idx1", 32'(rob_pkt[1].i_rob_idx), 32'd0);
        tick();
        rob_idx = 4'd5;

        // Fill the queue behind full stations, then flush.
        res_full = 4'hF;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(2'b11, mkInst(1'b1, 5'd11, 5'd0, 5'd0, 2'd0), mkInst(1'b1, 5'd12, 5'd0, 5'd0, 2'd1));
        end
        checkOutput("t6_ready_at6", 32'(in_ready), 32'd1);
        checkOutput("t6_stall_at6", 32'(stall_dispatch), 32'd1);
        applyStimulus(2'b11, mkInst(1'b1, 5'd13, 5'd0, 5'd0, 2'd0), mkInst(1'b1, 5'd14, 5'd0, 5'd0, 2'd1));
        checkOutput("t6_ready_at8", 32'(in_ready), 32'd0);
        res_full = '0;
        flush    = 1'b1;
        in_valid = 2'b11;
        #1;
        checkOutput("t6_flush_valid", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'd0);
        checkOutput("t6_flush_preg_req", 32'(preg_request), 32'd0);
        checkOutput("t6_flush_rename", 32'(rename_en), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = '0;
        #1;
        checkOutput("t6_post_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_post_valid", {30'd0, rob_pkt[1].i_valid, rob_pkt[0].i_valid}, 32'd0);
        checkOutput("t6_post_stall", 32'(stall_dispatch), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispatch_wide.md
Name: dispatch_wide

Overview:
Parametrised N-lane successor to the single-instruction dispatch stage. Sits between decode and the rename/ROB/RS structures. Buffers decoded instructions in a small in-order queue and dispatches an in-order prefix of up to WIDTH instructions per cycle. Each dispatched instruction is renamed (RAT, free list), given a ROB index and sent to a reservation station, with bypass for dependencies inside the same dispatch group.

Parameters:
WIDTH, 2, dispatch lanes per cycle (1..4)
QDEPTH, 8, holding-queue entries; power of 2, >= 2*WIDTH

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
flush  in  1  branch-recovery flush; empties queue
in_valid  in  WIDTH  decode lane valids; contiguous from lane 0
in_inst  in  instr_pkt x WIDTH  decoded instructions, lane 0 oldest
in_ready  out  1  queue can accept WIDTH entries this cycle
rs1_archreg  out  ARCH_WIDTH x WIDTH  RAT read addresses
rs2_archreg  out  ARCH_WIDTH x WIDTH  RAT read addresses
rs1_mapping  in  PHYS_WIDTH x WIDTH  RAT combinational read data
rs2_mapping  in  PHYS_WIDTH x WIDTH  RAT combinational read data
rename_en  out  WIDTH  RAT write enable per lane
rat_arch_dst  out  ARCH_WIDTH x WIDTH  arch reg renamed
rat_phys_dst  out  PHYS_WIDTH x WIDTH  new phys reg; also invalidates valid array
fl_count  in  PHYS_WIDTH+1  free physical registers available
preg_addr  in  PHYS_WIDTH x WIDTH  next WIDTH free regs, slot 0 oldest
preg_request  out  WIDTH  free-list pop, thermometer (popcount = pops)
rob_free  in  ROB_ADDR_WIDTH+1  free ROB entries
rob_idx  in  ROB_ADDR_WIDTH  ROB tail index
rob_pkt  out  instr_pkt x WIDTH  per-lane packet to ROB; i_valid = dispatched
res_full  in  NUM_RES_STATIONS  per-station full
res_entry_out  out  res_entry x WIDTH  per-lane RS entry
stall_dispatch  out  1  queue non-empty and zero lanes dispatched

Behaviour:
- Reset (rst low, async): head/tail/count = 0; in_ready = 1; all per-lane enables, preg_request, rob_pkt i_valid = 0; stall_dispatch = 0.
- Queue: in_ready = (QDEPTH - count_q) >= WIDTH (registered count, ignores same-cycle dequeue). Enqueue valid lanes at tail when in_ready. Simultaneous enqueue/dequeue allowed; count_next = count + enq - deq. Pointers wrap mod QDEPTH.
- Candidates: lane k = queue entry head+k when k < count_q, else invalid. Zero latency from queue register to dispatch outputs.
- Lane k dispatches iff lane k-1 dispatched (k>0), lane k valid, rob_free > k, cumulative rd-needing lanes 0..k <= fl_count, res_full[res_id] = 0, and no earlier dispatching lane this cycle targets the same res_id (one entry per station per cycle).
- Needs rd: i_uses_rd && rd_addr != 0. rd_addr = 0 never allocates or renames.
- Dispatched needs-rd lane k takes preg_addr[j], j = number of earlier needs-rd dispatched lanes; it asserts rename_en[k]. preg_request bit j is set for each such lane.
- rob_pkt[k].i_rob_idx = rob_idx + k, wrap mod 2^ROB_ADDR_WIDTH.
- Intra-group bypass: rs1_paddr/rs2_paddr of lane k = rat_phys_dst of the youngest earlier dispatching lane with a matching non-zero rd; otherwise RAT mapping.
- RAT writes for the same arch reg in one cycle: youngest lane wins; RAT resolves by lane order.
- res_entry_out[k] = {inst: rob_pkt[k], valid: 0, stall: 0}.
- flush: all dispatch outputs forced invalid that cycle, enqueue ignored, count/head/tail = 0 next edge. No free-list/ROB/RAT side effects.
- Empty queue: stall_dispatch = 0, no requests.

Optional Feature:
DISPATCH_PERF_EN: when defined, adds outputs perf_dispatched (32) and perf_stall (32). These are saturating counters of instructions dispatched and cycles with stall_dispatch=1, cleared by reset only. When undefined, the ports and logic are absent.

Test Plan:
- Reset then enqueue 2 ALU instrs rd=x1,x2 to different stations, fl_count=10, rob_free=8, rob_idx=5 -> both dispatch next cycle; ROB idx 5,6; preg_request=2'b11.
- Lane1 rs1=x1, lane0 rd=x1, preg_addr[0]=17 -> lane1 rs1_paddr=17, not the RAT value.
- Both lanes target same station -> lane0 dispatches, lane1 dispatches next cycle, count 2->1->0.
- fl_count=1, both lanes need rd -> only lane0 dispatches; lane with rd=x0 needs no preg and dispatches with fl_count=0.
- rob_idx=2^ROB_ADDR_WIDTH-1, 2 lanes -> idx wraps to max, 0.
- Queue holds 6 (QDEPTH=8), assert flush with in_valid=2'b11 -> no dispatch, count=0 next cycle, in_ready=1.
